// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and the filter blocks it feeds.
// Window positions are numbered row-major with P_TL at index 0.
package window_3x3_gen_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam int P_TL = 0;
    localparam int P_TM = 1;
    localparam int P_TR = 2;
    localparam int P_ML = 3;
    localparam int P_MM = 4;
    localparam int P_MR = 5;
    localparam int P_BL = 6;
    localparam int P_BM = 7;
    localparam int P_BR = 8;

    localparam int WIN_SIZE = 9;

    function automatic int win_index(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out stream bundle for window_3x3_gen.
// The master drives pixels and window back-pressure; the slave (the generator) returns windows.
interface window_3x3_gen_if
    import window_3x3_gen_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [DATA_W-1:0] in_pixel;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_p1;
    logic [DATA_W-1:0] out_p2;
    logic [DATA_W-1:0] out_p3;
    logic [DATA_W-1:0] out_p4;
    logic [DATA_W-1:0] out_p5;
    logic [DATA_W-1:0] out_p6;
    logic [DATA_W-1:0] out_p7;
    logic [DATA_W-1:0] out_p8;
    logic [DATA_W-1:0] out_p9;
    logic              out_last;

    modport master (
        output in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, out_last,
        input  out_p1, out_p2, out_p3, out_p4, out_p5, out_p6, out_p7, out_p8, out_p9
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, out_last,
        output out_p1, out_p2, out_p3, out_p4, out_p5, out_p6, out_p7, out_p8, out_p9
    );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One line of pixel storage: asynchronous read, synchronous write.
// A read and write to the same address in one cycle returns the old contents.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, interior 3x3 windows out.
// Output registers hold while the consumer stalls; there is no input skid buffer.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    window_3x3_gen_if.slave  bus
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic              in_ready;
    logic              accept;
    logic              emit;

    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;

    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    logic [DATA_W-1:0] win_q [WIN_SIZE];
    logic [DATA_W-1:0] win_d [WIN_SIZE];
    logic [DATA_W-1:0] out_q [WIN_SIZE];
    logic [DATA_W-1:0] out_d [WIN_SIZE];
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    // A start-of-frame pixel is placed at (0,0) no matter where the counters were.
    always_comb begin
        in_ready = !out_valid_q || bus.out_ready;
        accept   = bus.in_valid && in_ready;
        cur_col  = bus.in_sof ? '0 : col_q;
        cur_row  = bus.in_sof ? '0 : row_q;
        emit     = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk    (clk),
        .we     (accept),
        .addr   (cur_col),
        .wdata  (bus.in_pixel),
        .rdata  (lb0_rd)
    );

    line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk    (clk),
        .we     (accept),
        .addr   (cur_col),
        .wdata  (lb0_rd),
        .rdata  (lb1_rd)
    );

    // Window slides one column left; the new right column is two rows up, one row up, current.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[win_index(r, 0)] = win_q[win_index(r, 1)];
                win_d[win_index(r, 1)] = win_q[win_index(r, 2)];
            end
            win_d[P_TR] = lb1_rd;
            win_d[P_MR] = lb0_rd;
            win_d[P_BR] = bus.in_pixel;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_d       = win_d;
            out_valid_d = 1'b1;
            out_last_d  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                win_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
            out_q       <= out_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_p1    = out_q[P_TL];
    assign bus.out_p2    = out_q[P_TM];
    assign bus.out_p3    = out_q[P_TR];
    assign bus.out_p4    = out_q[P_ML];
    assign bus.out_p5    = out_q[P_MM];
    assign bus.out_p6    = out_q[P_MR];
    assign bus.out_p7    = out_q[P_BL];
    assign bus.out_p8    = out_q[P_BM];
    assign bus.out_p9    = out_q[P_BR];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x4 image whose pixel value is row*4+col.
// Expected windows are queued ahead of the stimulus; a monitor pops one per output transfer.
module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    window_3x3_gen_if #(.DATA_W(DW)) bus_if ();

    window_3x3_gen #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    typedef struct packed {
        logic [8:0][DW-1:0] p;
        logic               last;
    } win_t;

    win_t exp_q [$];
    win_t mon_exp;
    win_t mon_act;
    int   checks       = 0;
    int   passes       = 0;
    int   windows_seen = 0;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Window whose top-left pixel value is tl, for the row*4+col image.
    function automatic win_t makeWindow(input int tl, input bit last);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w.p[r*3+c] = DW'(tl + r*IW + c);
        w.last = last;
        return w;
    endfunction

    function automatic win_t actualWindow();
        win_t w;
        w.p[0] = bus_if.out_p1; w.p[1] = bus_if.out_p2; w.p[2] = bus_if.out_p3;
        w.p[3] = bus_if.out_p4; w.p[4] = bus_if.out_p5; w.p[5] = bus_if.out_p6;
        w.p[6] = bus_if.out_p7; w.p[7] = bus_if.out_p8; w.p[8] = bus_if.out_p9;
        w.last = bus_if.out_last;
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            windows_seen++;
            mon_act = actualWindow();
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_window: got %h, expected no window", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("window", 80'(mon_act), 80'(mon_exp));
            end
        end
    end

    task automatic pushFrame(input int base);
        exp_q.push_back(makeWindow(base + 0, 1'b0));
        exp_q.push_back(makeWindow(base + 1, 1'b0));
        exp_q.push_back(makeWindow(base + 4, 1'b0));
        exp_q.push_back(makeWindow(base + 5, 1'b1));
    endtask

    task automatic applyStimulus(input logic [DW-1:0] pix, input bit sof, input bit gaps);
        int n;
        bit acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus_if.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_pixel = pix;
        bus_if.in_sof   = sof;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            if (gaps) bus_if.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        if (!acc) begin
            checks++;
            $display("[TB] FAIL accept_timeout: pixel %0d not accepted, expected accept within 50 cycles", pix);
        end
    endtask

    task automatic sendFrame(input int base, input bit sof, input int first, input int count, input bit gaps);
        for (int i = first; i < first + count; i++)
            applyStimulus(DW'(base + i), sof && (i == 0), gaps);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_sof    = 1'b0;
        bus_if.in_pixel  = '0;
        bus_if.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 80'(bus_if.out_valid), 80'(0));
        checkOutput("reset_out_last",  80'(bus_if.out_last),  80'(0));
        checkOutput("reset_in_ready",  80'(bus_if.in_ready),  80'(1));
        checkOutput("reset_window",    80'(actualWindow()),   80'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] single frame");
        pushFrame(0);
        sendFrame(0, 1'b1, 0, 16, 1'b0);
        idle(3);

        $display("[TB] output hold");
        pushFrame(0);
        bus_if.out_ready = 1'b0;
        sendFrame(0, 1'b1, 0, 11, 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.in_pixel = DW'(11);
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 80'(bus_if.out_valid), 80'(1));
            checkOutput("hold_in_ready",  80'(bus_if.in_ready),  80'(0));
            checkOutput("hold_window",    80'(actualWindow()),   80'(makeWindow(0, 1'b0)));
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        sendFrame(0, 1'b0, 11, 5, 1'b0);
        idle(3);

        $display("[TB] back-to-back frames");
        pushFrame(0);
        pushFrame(100);
        sendFrame(0,   1'b1, 0, 16, 1'b0);
        sendFrame(100, 1'b0, 0, 16, 1'b0);
        idle(3);

        $display("[TB] abandoned frame");
        exp_q.push_back(makeWindow(0, 1'b0));
        exp_q.push_back(makeWindow(1, 1'b0));
        sendFrame(0, 1'b1, 0, 12, 1'b0);
        pushFrame(0);
        sendFrame(0, 1'b1, 0, 16, 1'b0);
        idle(3);

        $display("[TB] reset mid-frame");
        sendFrame(0, 1'b1, 0, 11, 1'b0);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midreset_out_valid", 80'(bus_if.out_valid), 80'(0));
            checkOutput("midreset_window",    80'(actualWindow()),   80'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushFrame(0);
        sendFrame(0, 1'b0, 0, 16, 1'b0);
        idle(3);

        $display("[TB] random valid/ready gaps");
        pushFrame(0);
        sendFrame(0, 1'b1, 0, 16, 1'b1);
        bus_if.out_ready = 1'b1;

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
        idle(3);
        checkOutput("queue_drained", 80'(exp_q.size()), 80'(0));
        checkOutput("window_count",  80'(windows_seen), 80'(30));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
